// File: rtl/lvds_rx_frame_check_pkg.sv
// Shared constants, frame FSM state type and counter helper for the LVDS
// 8b/10b link. The TX pattern generator imports the same package.
package lvds_link_pkg;

    localparam logic [7:0] COMMA_K28_5 = 8'hBC;
    localparam logic [7:0] HDR0        = 8'hEE;
    localparam logic [7:0] HDR1        = 8'h33;
    localparam logic [7:0] FIRST_BYTE  = 8'h34;
    localparam int         PAYLOAD_LEN = 124;
    localparam int         LOCK_COMMAS = 16;
    localparam int         UNLOCK_ERRS = 4;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        IDLE     = 2'd1,
        HDR      = 2'd2,
        PAYLOAD  = 2'd3
    } frame_state_e;

    // Add a small increment to a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/lvds_rx_frame_check_if.sv
// Decoded-symbol input bus plus payload/status outputs of the frame checker.
interface lvds_rx_frame_check_if;
    logic        rx_valid;
    logic        rx_k;
    logic [7:0]  rx_data;
    logic        rx_code_err;
    logic        pl_valid;
    logic [7:0]  pl_data;
    logic        pl_sof;
    logic        pl_eof;
    logic        frame_ok;
    logic        frame_err;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    modport master (
        output rx_valid, rx_k, rx_data, rx_code_err,
        input  pl_valid, pl_data, pl_sof, pl_eof, frame_ok, frame_err,
               locked, frame_cnt, err_cnt
    );

    modport slave (
        input  rx_valid, rx_k, rx_data, rx_code_err,
        output pl_valid, pl_data, pl_sof, pl_eof, frame_ok, frame_err,
               locked, frame_cnt, err_cnt
    );
endinterface

// File: rtl/lvds_rx_lock_mon.sv
// Link lock monitor: counts runs of good commas to acquire lock and runs of
// bad symbols to drop it. lock_acq/lock_lost flag the symbol that causes the
// transition so the frame FSM can move on the same accepted symbol.
module lvds_rx_lock_mon
    import lvds_link_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    input  logic       sym_k,
    input  logic [7:0] sym_data,
    input  logic       sym_code_err,
    output logic       locked,
    output logic       lock_acq,
    output logic       lock_lost
);

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COMMAS - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

    logic [7:0] comma_run_r;
    logic [7:0] bad_run_r;
    logic       locked_r;
    logic       good_comma_s;
    logic       bad_s;
    logic       lock_acq_s;
    logic       lock_lost_s;

    // Classify the current symbol and detect the lock transition it causes.
    always_comb begin
        good_comma_s = sym_k && (sym_data == COMMA_K28_5) && !sym_code_err;
        bad_s        = sym_code_err || (sym_k && (sym_data != COMMA_K28_5));
        lock_acq_s   = sym_valid && !locked_r && good_comma_s && (comma_run_r == LOCK_LAST);
        lock_lost_s  = sym_valid && locked_r && bad_s && (bad_run_r == UNLOCK_LAST);
    end

    // Run counters and the registered lock flag; idle cycles hold everything.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            comma_run_r <= 8'd0;
            bad_run_r   <= 8'd0;
            locked_r    <= 1'b0;
        end else if (sym_valid) begin
            if (locked_r) begin
                comma_run_r <= 8'd0;
                if (lock_lost_s) begin
                    locked_r  <= 1'b0;
                    bad_run_r <= 8'd0;
                end else if (bad_s) begin
                    bad_run_r <= bad_run_r + 8'd1;
                end else begin
                    bad_run_r <= 8'd0;
                end
            end else begin
                bad_run_r <= 8'd0;
                if (lock_acq_s) begin
                    locked_r    <= 1'b1;
                    comma_run_r <= 8'd0;
                end else if (good_comma_s) begin
                    comma_run_r <= comma_run_r + 8'd1;
                end else begin
                    comma_run_r <= 8'd0;
                end
            end
        end
    end

    assign locked    = locked_r;
    assign lock_acq  = lock_acq_s;
    assign lock_lost = lock_lost_s;

endmodule

// File: rtl/lvds_rx_frame_check.sv
// Receive frame parser: finds the EE 33 header after lock, streams the
// payload out one cycle later and checks it against the incrementing test
// pattern, with saturating good-frame and error counters.
module lvds_rx_frame_check
    import lvds_link_pkg::*;
(
    input  logic                 sys_clk,
    input  logic                 rst_n,
    lvds_rx_frame_check_if.slave bus
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    frame_state_e state_r, state_s;
    logic [7:0]   exp_r, exp_s;
    logic [7:0]   idx_r, idx_s;
    logic         mism_r, mism_s;
    logic         byte_bad_s;
    logic         emit_s, sof_s, eof_s, ok_s, ferr_s, junk_s, cerr_s;
    logic [1:0]   inc_s;
    logic         locked_s, lock_acq_s, lock_lost_s;

    logic         pl_valid_r;
    logic [7:0]   pl_data_r;
    logic         pl_sof_r;
    logic         pl_eof_r;
    logic         frame_ok_r;
    logic         frame_err_r;
    logic [15:0]  frame_cnt_r;
    logic [15:0]  err_cnt_r;

    lvds_rx_lock_mon u_lock_mon (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .sym_valid    (bus.rx_valid),
        .sym_k        (bus.rx_k),
        .sym_data     (bus.rx_data),
        .sym_code_err (bus.rx_code_err),
        .locked       (locked_s),
        .lock_acq     (lock_acq_s),
        .lock_lost    (lock_lost_s)
    );

    // Frame FSM and pattern check for the symbol currently on the bus.
    always_comb begin
        state_s    = state_r;
        exp_s      = exp_r;
        idx_s      = idx_r;
        mism_s     = mism_r;
        emit_s     = 1'b0;
        sof_s      = 1'b0;
        eof_s      = 1'b0;
        ok_s       = 1'b0;
        ferr_s     = 1'b0;
        junk_s     = 1'b0;
        byte_bad_s = (bus.rx_data != exp_r) || bus.rx_code_err;
        cerr_s     = bus.rx_valid && bus.rx_code_err && locked_s;
        if (bus.rx_valid) begin
            if (lock_lost_s) begin
                // Losing lock aborts any frame that has started.
                state_s = UNLOCKED;
                ferr_s  = (state_r == HDR) || (state_r == PAYLOAD);
            end else begin
                case (state_r)
                    UNLOCKED: begin
                        if (lock_acq_s) begin
                            state_s = IDLE;
                        end else begin
                            state_s = UNLOCKED;
                        end
                    end
                    IDLE: begin
                        // Corrupted symbols are counted as code errors only.
                        if (!bus.rx_k && !bus.rx_code_err) begin
                            if (bus.rx_data == HDR0) begin
                                state_s = HDR;
                            end else begin
                                junk_s = 1'b1;
                            end
                        end else begin
                            state_s = IDLE;
                        end
                    end
                    HDR: begin
                        if (!bus.rx_k && !bus.rx_code_err && (bus.rx_data == HDR1)) begin
                            state_s = PAYLOAD;
                            exp_s   = FIRST_BYTE;
                            idx_s   = 8'd0;
                            mism_s  = 1'b0;
                        end else begin
                            state_s = IDLE;
                            ferr_s  = 1'b1;
                        end
                    end
                    PAYLOAD: begin
                        if (bus.rx_k) begin
                            // Truncated frame: no end-of-frame beat.
                            state_s = IDLE;
                            ferr_s  = 1'b1;
                        end else begin
                            emit_s = 1'b1;
                            sof_s  = (idx_r == 8'd0);
                            eof_s  = (idx_r == LAST_IDX);
                            if (idx_r == LAST_IDX) begin
                                state_s = IDLE;
                                ok_s    = !(mism_r || byte_bad_s);
                                ferr_s  = mism_r || byte_bad_s;
                            end else begin
                                idx_s  = idx_r + 8'd1;
                                exp_s  = exp_r + 8'd1;
                                mism_s = mism_r || byte_bad_s;
                            end
                        end
                    end
                    default: begin
                        state_s = UNLOCKED;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
        inc_s = {1'b0, ferr_s} + {1'b0, cerr_s} + {1'b0, junk_s};
    end

    // FSM state, registered outputs and saturating counters.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= UNLOCKED;
            exp_r       <= 8'd0;
            idx_r       <= 8'd0;
            mism_r      <= 1'b0;
            pl_valid_r  <= 1'b0;
            pl_data_r   <= 8'd0;
            pl_sof_r    <= 1'b0;
            pl_eof_r    <= 1'b0;
            frame_ok_r  <= 1'b0;
            frame_err_r <= 1'b0;
            frame_cnt_r <= 16'd0;
            err_cnt_r   <= 16'd0;
        end else begin
            state_r     <= state_s;
            exp_r       <= exp_s;
            idx_r       <= idx_s;
            mism_r      <= mism_s;
            pl_valid_r  <= emit_s;
            pl_data_r   <= emit_s ? bus.rx_data : 8'd0;
            pl_sof_r    <= sof_s;
            pl_eof_r    <= eof_s;
            frame_ok_r  <= ok_s;
            frame_err_r <= ferr_s;
            frame_cnt_r <= sat_add16(frame_cnt_r, {1'b0, ok_s});
            err_cnt_r   <= sat_add16(err_cnt_r, inc_s);
        end
    end

    assign bus.pl_valid  = pl_valid_r;
    assign bus.pl_data   = pl_data_r;
    assign bus.pl_sof    = pl_sof_r;
    assign bus.pl_eof    = pl_eof_r;
    assign bus.frame_ok  = frame_ok_r;
    assign bus.frame_err = frame_err_r;
    assign bus.locked    = locked_s;
    assign bus.frame_cnt = frame_cnt_r;
    assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_lvds_rx_frame_check.sv
// Bench for lvds_rx_frame_check: randomized symbol streams with idle bubbles,
// checked against a frame-level reference model kept in the bench.
module tb_lvds_rx_frame_check;
    import lvds_link_pkg::*;

    typedef struct packed {
        logic       sof;
        logic       eof;
        logic [7:0] d;
    } beat_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    lvds_rx_frame_check_if bus_if ();

    lvds_rx_frame_check dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Captured DUT activity
    beat_t cap_q[$];
    int    mon_ok   = 0;
    int    mon_ferr = 0;

    // Reference model
    beat_t    exp_q[$];
    logic [7:0] frame_bytes[$];
    int       m_ok, m_ferr, m_fcnt, m_ecnt;
    bit       m_locked, m_ce;
    int       m_commas, m_bads, m_mode;

    always @(negedge sys_clk) begin
        if (bus_if.pl_valid === 1'b1) cap_q.push_back({bus_if.pl_sof, bus_if.pl_eof, bus_if.pl_data});
        if (bus_if.frame_ok === 1'b1) mon_ok++;
        if (bus_if.frame_err === 1'b1) mon_ferr++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        exp_q.delete(); frame_bytes.delete(); cap_q.delete();
        m_ok = 0; m_ferr = 0; m_fcnt = 0; m_ecnt = 0;
        m_locked = 0; m_ce = 0; m_commas = 0; m_bads = 0; m_mode = 0;
        mon_ok = 0; mon_ferr = 0;
    endtask

    task automatic frame_fail();
        m_ferr++; m_ecnt++;
    endtask

    // Apply one accepted symbol to the model. Mode: 0 idle, 1 header seen, 2 payload.
    task automatic model_sym(input logic k, input logic [7:0] d, input logic ce);
        bit bad, good_comma, pattern_ok;
        bad        = ce || (k && d != COMMA_K28_5);
        good_comma = k && d == COMMA_K28_5 && !ce;
        if (!m_locked) begin
            m_commas = good_comma ? m_commas + 1 : 0;
            if (m_commas == LOCK_COMMAS) begin
                m_locked = 1; m_commas = 0; m_bads = 0; m_mode = 0;
            end
            return;
        end
        if (ce) m_ecnt++;
        m_bads = bad ? m_bads + 1 : 0;
        if (m_bads == UNLOCK_ERRS) begin
            m_locked = 0; m_commas = 0;
            if (m_mode != 0) frame_fail();
            m_mode = 0;
            return;
        end
        case (m_mode)
            0: if (!k && !ce) begin
                   if (d == HDR0) m_mode = 1;
                   else m_ecnt++;
               end
            1: if (!k && !ce && d == HDR1) begin
                   m_mode = 2; frame_bytes.delete(); m_ce = 0;
               end else begin
                   frame_fail(); m_mode = 0;
               end
            default: if (k) begin
                   frame_fail(); m_mode = 0;
               end else begin
                   exp_q.push_back({frame_bytes.size() == 0, frame_bytes.size() == PAYLOAD_LEN - 1, d});
                   frame_bytes.push_back(d);
                   m_ce = m_ce | ce;
                   if (frame_bytes.size() == PAYLOAD_LEN) begin
                       pattern_ok = !m_ce;
                       foreach (frame_bytes[i])
                           if (frame_bytes[i] != 8'((int'(FIRST_BYTE) + i) % 256)) pattern_ok = 0;
                       if (pattern_ok) begin m_ok++; m_fcnt++; end
                       else frame_fail();
                       m_mode = 0;
                   end
               end
        endcase
    endtask

    // Drive one symbol, optionally preceded by a random idle bubble.
    task automatic send(input logic k, input logic [7:0] d, input logic ce);
        if ($urandom_range(0, 3) == 0) begin
            @(posedge sys_clk); #1;
            bus_if.rx_valid = 1'b0; bus_if.rx_k = 1'($urandom);
            bus_if.rx_data = 8'($urandom); bus_if.rx_code_err = 1'($urandom);
        end
        @(posedge sys_clk); #1;
        bus_if.rx_valid = 1'b1; bus_if.rx_k = k; bus_if.rx_data = d; bus_if.rx_code_err = ce;
    endtask

    task automatic sym(input logic k, input logic [7:0] d, input logic ce);
        model_sym(k, d, ce);
        send(k, d, ce);
    endtask

    task automatic commas(input int n);
        for (int i = 0; i < n; i++) sym(1'b1, COMMA_K28_5, 1'b0);
    endtask

    // Stop driving and wait until the last symbol's outputs are visible.
    task automatic flush();
        @(posedge sys_clk); #1;
        bus_if.rx_valid = 1'b0;
        @(negedge sys_clk);
    endtask

    // kind: 0 good, 1 corrupt byte, 2 code error byte, 3 truncated, 4 bad header, 5 junk then good
    task automatic frame(input int kind, input int pos);
        logic [7:0] d;
        if (kind == 5) begin
            d = 8'($urandom);
            if (d == HDR0) d = 8'h00;
            sym(1'b0, d, 1'b0);
        end
        sym(1'b0, HDR0, 1'b0);
        if (kind == 4) begin
            if ($urandom_range(0, 1) == 1) sym(1'b1, COMMA_K28_5, 1'b0);
            else sym(1'b0, 8'h55, 1'b0);
            return;
        end
        sym(1'b0, HDR1, 1'b0);
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            if (kind == 3 && i == pos) begin
                sym(1'b1, COMMA_K28_5, 1'b0);
                return;
            end
            d = 8'(int'(FIRST_BYTE) + i);
            if (kind == 1 && i == pos) d = (pos == 50) ? 8'h00 : d ^ 8'($urandom_range(1, 255));
            sym(1'b0, d, (kind == 2 && i == pos) ? 1'b1 : 1'b0);
        end
    endtask

    function automatic int beats_diff();
        if (cap_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        bus_if.rx_valid = 1'b0; bus_if.rx_k = 1'b0; bus_if.rx_data = 8'd0; bus_if.rx_code_err = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge sys_clk);
        tests_run++;
        if ({bus_if.pl_valid, bus_if.pl_data, bus_if.pl_sof, bus_if.pl_eof, bus_if.frame_ok,
             bus_if.frame_err, bus_if.locked} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got pl_valid=%b pl_data=%h sof=%b eof=%b ok=%b err=%b locked=%b, want all 0",
                     bus_if.pl_valid, bus_if.pl_data, bus_if.pl_sof, bus_if.pl_eof,
                     bus_if.frame_ok, bus_if.frame_err, bus_if.locked);
        end
        tests_run++;
        if (bus_if.frame_cnt !== 16'd0 || bus_if.err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: frame_cnt=%0d err_cnt=%0d, want 0 0", bus_if.frame_cnt, bus_if.err_cnt);
        end
    endtask

    task automatic test_good_frame();
        int d;
        commas(15); flush();
        tests_run++;
        if (bus_if.locked !== 1'b0) begin
            tests_failed++; $display("FAIL lock_after_15: locked=%b want 0", bus_if.locked);
        end
        commas(1); flush();
        tests_run++;
        if (bus_if.locked !== 1'b1) begin
            tests_failed++; $display("FAIL lock_after_16: locked=%b want 1", bus_if.locked);
        end
        frame(0, 0); commas(4); flush();
        d = beats_diff();
        tests_run++;
        if (d != -1) begin
            tests_failed++; $display("FAIL good_beats: got %0d beats want %0d, first diff %0d", cap_q.size(), exp_q.size(), d);
        end
        tests_run++;
        if (cap_q.size() != PAYLOAD_LEN || cap_q[0] !== {1'b1, 1'b0, 8'h34} || cap_q[PAYLOAD_LEN-1] !== {1'b0, 1'b1, 8'hAF}) begin
            tests_failed++; $display("FAIL good_sof_eof: %0d beats, sof/eof beats not 0x34/0xAF", cap_q.size());
        end
        tests_run++;
        if (mon_ok != 1 || mon_ferr != 0 || bus_if.frame_cnt !== 16'd1 || bus_if.err_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL good_counts: ok=%0d err=%0d frame_cnt=%0d err_cnt=%0d, want 1 0 1 0",
                     mon_ok, mon_ferr, bus_if.frame_cnt, bus_if.err_cnt);
        end
    endtask

    task automatic test_corrupt();
        int d;
        frame(1, 50); commas(3); flush();
        d = beats_diff();
        tests_run++;
        if (d != -1 || cap_q.size() != 2 * PAYLOAD_LEN) begin
            tests_failed++; $display("FAIL corrupt_beats: got %0d beats want %0d, first diff %0d", cap_q.size(), exp_q.size(), d);
        end
        tests_run++;
        if (mon_ferr != 1 || bus_if.frame_cnt !== 16'd1 || bus_if.err_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL corrupt_counts: frame_err=%0d frame_cnt=%0d err_cnt=%0d, want 1 1 1",
                     mon_ferr, bus_if.frame_cnt, bus_if.err_cnt);
        end
    endtask

    task automatic test_truncate();
        int d;
        frame(3, 60); commas(2); frame(0, 0); commas(2); flush();
        d = beats_diff();
        tests_run++;
        if (d != -1) begin
            tests_failed++; $display("FAIL trunc_beats: got %0d beats want %0d, first diff %0d", cap_q.size(), exp_q.size(), d);
        end
        tests_run++;
        if (mon_ok != m_ok || mon_ferr != m_ferr || bus_if.frame_cnt !== 16'(m_fcnt) || bus_if.err_cnt !== 16'(m_ecnt)) begin
            tests_failed++;
            $display("FAIL trunc_counts: ok=%0d/%0d err=%0d/%0d frame_cnt=%0d/%0d err_cnt=%0d/%0d (got/want)",
                     mon_ok, m_ok, mon_ferr, m_ferr, bus_if.frame_cnt, m_fcnt, bus_if.err_cnt, m_ecnt);
        end
    endtask

    task automatic test_no_lock();
        do_reset();
        commas(15); frame(0, 0); flush();
        tests_run++;
        if (bus_if.locked !== 1'b0 || cap_q.size() != 0) begin
            tests_failed++; $display("FAIL nolock: locked=%b beats=%0d, want 0 0", bus_if.locked, cap_q.size());
        end
        commas(16); flush();
        tests_run++;
        if (bus_if.locked !== 1'b1) begin
            tests_failed++; $display("FAIL relock_16: locked=%b want 1", bus_if.locked);
        end
    endtask

    task automatic test_unlock();
        for (int i = 0; i < 3; i++) sym(1'b1, COMMA_K28_5, 1'b1);
        flush();
        tests_run++;
        if (bus_if.locked !== 1'b1) begin
            tests_failed++; $display("FAIL unlock_after_3: locked=%b want 1", bus_if.locked);
        end
        sym(1'b1, COMMA_K28_5, 1'b1); flush();
        tests_run++;
        if (bus_if.locked !== 1'b0 || bus_if.err_cnt !== 16'd4) begin
            tests_failed++; $display("FAIL unlock_after_4: locked=%b err_cnt=%0d, want 0 4", bus_if.locked, bus_if.err_cnt);
        end
        commas(15); flush();
        tests_run++;
        if (bus_if.locked !== 1'b0) begin
            tests_failed++; $display("FAIL unlock_relock_15: locked=%b want 0", bus_if.locked);
        end
        commas(1); flush();
        tests_run++;
        if (bus_if.locked !== 1'b1) begin
            tests_failed++; $display("FAIL unlock_relock_16: locked=%b want 1", bus_if.locked);
        end
    endtask

    task automatic test_random_back_to_back();
        int d;
        for (int f = 0; f < 24; f++) begin
            frame($urandom_range(0, 5), $urandom_range(1, PAYLOAD_LEN - 2));
            commas($urandom_range(0, 3));
        end
        for (int f = 0; f < 3; f++) frame(0, 0);
        commas(2); flush();
        d = beats_diff();
        tests_run++;
        if (d != -1) begin
            tests_failed++; $display("FAIL random_beats: got %0d beats want %0d, first diff %0d", cap_q.size(), exp_q.size(), d);
        end
        tests_run++;
        if (mon_ok != m_ok || mon_ferr != m_ferr || bus_if.frame_cnt !== 16'(m_fcnt) ||
            bus_if.err_cnt !== 16'(m_ecnt) || bus_if.locked !== 1'(m_locked)) begin
            tests_failed++;
            $display("FAIL random_counts: ok=%0d/%0d err=%0d/%0d frame_cnt=%0d/%0d err_cnt=%0d/%0d locked=%b/%b (got/want)",
                     mon_ok, m_ok, mon_ferr, m_ferr, bus_if.frame_cnt, m_fcnt, bus_if.err_cnt, m_ecnt,
                     bus_if.locked, m_locked);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        sym(1'b0, HDR0, 1'b0); sym(1'b0, HDR1, 1'b0);
        for (int i = 0; i < 30; i++) sym(1'b0, 8'(int'(FIRST_BYTE) + i), 1'b0);
        @(negedge sys_clk);
        tests_run++;
        if (bus_if.pl_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mid_pl_valid: pl_valid=%b want 1", bus_if.pl_valid);
        end
        bus_if.rx_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus_if.pl_valid, bus_if.pl_data, bus_if.pl_sof, bus_if.pl_eof, bus_if.frame_ok,
             bus_if.frame_err, bus_if.locked, bus_if.frame_cnt, bus_if.err_cnt} !== 46'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: pl_valid=%b locked=%b frame_cnt=%0d err_cnt=%0d, want all 0",
                     bus_if.pl_valid, bus_if.locked, bus_if.frame_cnt, bus_if.err_cnt);
        end
        do_reset();
        commas(5); frame(0, 0); commas(16); frame(0, 0); commas(2); flush();
        d = beats_diff();
        tests_run++;
        if (d != -1 || cap_q.size() != PAYLOAD_LEN || mon_ok != 1 || bus_if.frame_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL post_reset: beats=%0d/%0d diff=%0d ok=%0d frame_cnt=%0d, want one good frame",
                     cap_q.size(), exp_q.size(), d, mon_ok, bus_if.frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_corrupt();
        test_truncate();
        test_no_lock();
        test_unlock();
        test_random_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
